// File: rtl/htif_csr_initiator.sv
// Host-side HTIF CSR initiator: one outstanding CSR read/write at a time,
// with a target reset pulse generator and a reply timeout.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// RST_HOLD | target_reset driven high, stale replies drained, hung cleared on exit
// IDLE     | waiting for a host command or a reset request
// REQ      | csr_req_valid asserted until the tile accepts the request
// WAIT     | csr_rep_ready asserted until the tile replies or the timer expires
// RESP     | response presented to the host until rsp_ready
module htif_csr_initiator #(
    parameter int XLEN         = 32,
    parameter int ADDR_W       = 12,
    parameter int TIMEOUT      = 1024,
    parameter int RESET_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_rw,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [XLEN-1:0]   cmd_wdata,
    input  logic              reset_req,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err,
    output logic              csr_req_valid,
    input  logic              csr_req_ready,
    output logic              csr_req_rw,
    output logic [ADDR_W-1:0] csr_req_addr,
    output logic [XLEN-1:0]   csr_req_data,
    input  logic              csr_rep_valid,
    output logic              csr_rep_ready,
    input  logic [XLEN-1:0]   csr_rep_data,
    output logic              target_reset,
    output logic              hung
);

    localparam int TO_W   = $clog2(TIMEOUT);
    localparam int HOLD_W = $clog2(RESET_CYCLES);

    // Both timers count down to zero; zero is the terminal count.
    localparam logic [TO_W-1:0]   TO_INIT   = TO_W'(TIMEOUT - 1);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RESET_CYCLES - 1);

    typedef enum logic [2:0] {
        RST_HOLD,
        IDLE,
        REQ,
        WAIT,
        RESP
    } state_t;

    state_t            state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              target_reset_q, target_reset_d;
    logic              hung_q, hung_d;
    logic              req_rw_q, req_rw_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [XLEN-1:0]   req_data_q, req_data_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              to_expired;

    assign to_expired = (to_cnt_q == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= RST_HOLD;
            hold_cnt_q     <= HOLD_INIT;
            to_cnt_q       <= '0;
            target_reset_q <= 1'b1;
            hung_q         <= 1'b0;
            req_rw_q       <= 1'b0;
            req_addr_q     <= '0;
            req_data_q     <= '0;
            rdata_q        <= '0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            hold_cnt_q     <= hold_cnt_d;
            to_cnt_q       <= to_cnt_d;
            target_reset_q <= target_reset_d;
            hung_q         <= hung_d;
            req_rw_q       <= req_rw_d;
            req_addr_q     <= req_addr_d;
            req_data_q     <= req_data_d;
            rdata_q        <= rdata_d;
            err_q          <= err_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        hold_cnt_d     = hold_cnt_q;
        to_cnt_d       = to_cnt_q;
        target_reset_d = target_reset_q;
        hung_d         = hung_q;
        req_rw_d       = req_rw_q;
        req_addr_d     = req_addr_q;
        req_data_d     = req_data_q;
        rdata_d        = rdata_q;
        err_d          = err_q;

        case (state_q)
            RST_HOLD: begin
                if (hold_cnt_q == '0) begin
                    state_d        = IDLE;
                    target_reset_d = 1'b0;
                    hung_d         = 1'b0;
                end else begin
                    hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                end
            end
            IDLE: begin
                if (reset_req) begin
                    state_d        = RST_HOLD;
                    hold_cnt_d     = HOLD_INIT;
                    target_reset_d = 1'b1;
                end else if (cmd_valid) begin
                    req_rw_d   = cmd_rw;
                    req_addr_d = cmd_addr;
                    req_data_d = cmd_wdata;
                    to_cnt_d   = TO_INIT;
                    if (hung_q) begin
                        // A dead target gets no more HTIF traffic until reset.
                        state_d = RESP;
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (to_expired) begin
                    state_d = RESP;
                    rdata_d = '0;
                    err_d   = 1'b1;
                    hung_d  = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q - TO_W'(1);
                    if (csr_req_ready) begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                // A reply landing on the expiry cycle still counts as a good reply.
                if (csr_rep_valid) begin
                    state_d = RESP;
                    rdata_d = csr_rep_data;
                    err_d   = 1'b0;
                end else if (to_expired) begin
                    state_d = RESP;
                    rdata_d = '0;
                    err_d   = 1'b1;
                    hung_d  = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q - TO_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = RST_HOLD;
            end
        endcase
    end

    assign cmd_ready     = (state_q == IDLE) & ~reset_req;
    assign csr_req_valid = (state_q == REQ);
    assign rsp_valid     = (state_q == RESP);
    // Held low while rst is asserted; high for the whole RST_HOLD drain once released.
    assign csr_rep_ready = rst & ((state_q == WAIT) | (state_q == RST_HOLD));

    assign csr_req_rw    = req_rw_q;
    assign csr_req_addr  = req_addr_q;
    assign csr_req_data  = req_data_q;
    assign rsp_rdata     = rdata_q;
    assign rsp_err       = err_q;
    assign target_reset  = target_reset_q;
    assign hung          = hung_q;

endmodule

// File: tb/tb_htif_csr_initiator.sv
// Self-checking bench for htif_csr_initiator: directed scenarios followed by
// randomized traffic, all compared every cycle against a transaction-level model.
module tb_htif_csr_initiator;

    localparam int XLEN         = 32;
    localparam int ADDR_W       = 12;
    localparam int TIMEOUT      = 16;
    localparam int RESET_CYCLES = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_rw;
    logic [ADDR_W-1:0] cmd_addr;
    logic [XLEN-1:0]   cmd_wdata;
    logic              reset_req;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [XLEN-1:0]   rsp_rdata;
    logic              rsp_err;
    logic              csr_req_valid;
    logic              csr_req_ready;
    logic              csr_req_rw;
    logic [ADDR_W-1:0] csr_req_addr;
    logic [XLEN-1:0]   csr_req_data;
    logic              csr_rep_valid;
    logic              csr_rep_ready;
    logic [XLEN-1:0]   csr_rep_data;
    logic              target_reset;
    logic              hung;

    always #5 clk = ~clk;

    htif_csr_initiator #(
        .XLEN        (XLEN),
        .ADDR_W      (ADDR_W),
        .TIMEOUT     (TIMEOUT),
        .RESET_CYCLES(RESET_CYCLES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_rw       (cmd_rw),
        .cmd_addr     (cmd_addr),
        .cmd_wdata    (cmd_wdata),
        .reset_req    (reset_req),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .csr_req_valid(csr_req_valid),
        .csr_req_ready(csr_req_ready),
        .csr_req_rw   (csr_req_rw),
        .csr_req_addr (csr_req_addr),
        .csr_req_data (csr_req_data),
        .csr_rep_valid(csr_rep_valid),
        .csr_rep_ready(csr_rep_ready),
        .csr_rep_data (csr_rep_data),
        .target_reset (target_reset),
        .hung         (hung)
    );

    // Transaction-level model: a reset-pulse budget plus one in-flight transaction record.
    int                m_hold_left;
    bit                m_active;
    bit                m_sent;
    bit                m_posted;
    bit                m_hung;
    int                m_age;
    bit                m_rw;
    logic [ADDR_W-1:0] m_addr;
    logic [XLEN-1:0]   m_wdata;
    logic [XLEN-1:0]   m_rdata;
    bit                m_err;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, want, $time);
        end
    endtask

    task automatic model_reset();
        m_hold_left = RESET_CYCLES;
        m_active    = 1'b0;
        m_sent      = 1'b0;
        m_posted    = 1'b0;
        m_hung      = 1'b0;
        m_age       = 0;
    endtask

    task automatic model_step();
        if (m_hold_left > 0) begin
            m_hold_left--;
            if (m_hold_left == 0) m_hung = 1'b0;
        end else if (!m_active) begin
            if (reset_req) begin
                m_hold_left = RESET_CYCLES;
            end else if (cmd_valid) begin
                m_active = 1'b1;
                m_age    = 0;
                m_sent   = 1'b0;
                m_rw     = cmd_rw;
                m_addr   = cmd_addr;
                m_wdata  = cmd_wdata;
                m_posted = m_hung;
                if (m_hung) begin
                    m_rdata = '0;
                    m_err   = 1'b1;
                end
            end
        end else if (!m_posted) begin
            if (m_sent && csr_rep_valid) begin
                m_posted = 1'b1;
                m_rdata  = csr_rep_data;
                m_err    = 1'b0;
            end else if (m_age == TIMEOUT - 1) begin
                m_posted = 1'b1;
                m_rdata  = '0;
                m_err    = 1'b1;
                m_hung   = 1'b1;
            end else begin
                if (csr_req_ready) m_sent = 1'b1;
                m_age++;
            end
        end else if (rsp_ready) begin
            m_active = 1'b0;
        end
    endtask

    task automatic compare();
        bit holding, idle, in_req, in_wait, in_resp;
        holding = (m_hold_left > 0);
        idle    = !holding && !m_active;
        in_req  = m_active && !m_posted && !m_sent;
        in_wait = m_active && !m_posted && m_sent;
        in_resp = m_active && m_posted;
        check("target_reset", target_reset, holding);
        check("cmd_ready", cmd_ready, idle && !reset_req);
        check("csr_req_valid", csr_req_valid, in_req);
        check("csr_rep_ready", csr_rep_ready, rst && (holding || in_wait));
        check("rsp_valid", rsp_valid, in_resp);
        check("hung", hung, m_hung);
        if (in_req) begin
            check("csr_req_rw", csr_req_rw, m_rw);
            check("csr_req_addr", csr_req_addr, m_addr);
            check("csr_req_data", csr_req_data, m_wdata);
        end
        if (in_resp) begin
            check("rsp_rdata", rsp_rdata, m_rdata);
            check("rsp_err", rsp_err, m_err);
        end
    endtask

    // Called between a falling edge and the next rising edge; returns on the next falling edge.
    task automatic tick();
        #1 compare();
        @(posedge clk);
        if (rst) model_step();
        @(negedge clk);
    endtask

    task automatic hold_len(output int n);
        n = 0;
        for (int i = 0; i < 64; i++) begin
            #1;
            if (!target_reset) break;
            check("hold_cmd_ready_low", cmd_ready, 0);
            n++;
            tick();
        end
    endtask

    task automatic issue(input bit rw, input logic [ADDR_W-1:0] a, input logic [XLEN-1:0] d);
        bit accepted;
        accepted  = 1'b0;
        cmd_valid = 1'b1;
        cmd_rw    = rw;
        cmd_addr  = a;
        cmd_wdata = d;
        for (int i = 0; i < 50; i++) begin
            #1;
            accepted = cmd_ready;
            tick();
            if (accepted) break;
        end
        cmd_valid = 1'b0;
        if (!accepted) check("cmd_accept_bound", 0, 1);
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (rsp_valid) return;
            lat++;
            tick();
        end
        check("rsp_wait_bound", 0, 1);
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        int lat;
        int n_hi;
        rst           = 1'b0;
        cmd_valid     = 1'b0;
        cmd_rw        = 1'b0;
        cmd_addr      = '0;
        cmd_wdata     = '0;
        reset_req     = 1'b0;
        rsp_ready     = 1'b0;
        csr_req_ready = 1'b0;
        csr_rep_valid = 1'b0;
        csr_rep_data  = '0;
        model_reset();
        @(negedge clk);
        tick();
        tick();
        #1;
        check("por_target_reset", target_reset, 1);
        check("por_rsp_rdata", rsp_rdata, 0);
        check("por_rsp_err", rsp_err, 0);
        check("por_req_addr", csr_req_addr, 0);
        check("por_rep_ready", csr_rep_ready, 0);

        // Reset pulse length after power-on release
        rst = 1'b1;
        hold_len(n_hi);
        check("por_hold_len", n_hi, 16);
        check("post_hold_cmd_ready", cmd_ready, 1);

        // Plain read with a delayed reply
        csr_req_ready = 1'b1;
        issue(1'b0, 12'h780, 32'h0);
        #1;
        check("t2_req_valid", csr_req_valid, 1);
        check("t2_req_rw", csr_req_rw, 0);
        check("t2_req_addr", csr_req_addr, 12'h780);
        tick();
        #1 check("t2_req_one_cycle", csr_req_valid, 0);
        repeat (4) tick();
        csr_rep_data  = 32'hDEADBEEF;
        csr_rep_valid = 1'b1;
        tick();
        csr_rep_valid = 1'b0;
        wait_rsp(lat);
        check("t2_rdata", rsp_rdata, 32'hDEADBEEF);
        check("t2_err", rsp_err, 0);
        take_rsp();

        // Write with request back-pressure and response back-pressure
        csr_req_ready = 1'b0;
        issue(1'b1, 12'h51E, 32'h12345678);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t3_req_valid", csr_req_valid, 1);
            check("t3_req_rw", csr_req_rw, 1);
            check("t3_req_addr", csr_req_addr, 12'h51E);
            check("t3_req_data", csr_req_data, 32'h12345678);
            if (i == 3) csr_req_ready = 1'b1;
            tick();
        end
        csr_req_ready = 1'b0;
        #1 check("t3_req_dropped", csr_req_valid, 0);
        csr_rep_data  = 32'h0;
        csr_rep_valid = 1'b1;
        tick();
        csr_rep_valid = 1'b0;
        wait_rsp(lat);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t3_rsp_held", rsp_valid, 1);
            check("t3_rsp_rdata", rsp_rdata, 0);
            tick();
        end
        take_rsp();

        // Minimum latency with both HTIF handshakes tied high
        csr_req_ready = 1'b1;
        csr_rep_valid = 1'b1;
        csr_rep_data  = 32'hA5A50F0F;
        issue(1'b0, 12'h300, 32'h0);
        wait_rsp(lat);
        check("min_latency", lat, 3);
        check("min_lat_rdata", rsp_rdata, 32'hA5A50F0F);
        csr_rep_valid = 1'b0;
        take_rsp();

        // Reply arriving on the expiry cycle wins
        issue(1'b0, 12'h7C0, 32'h0);
        repeat (TIMEOUT - 1) tick();
        csr_rep_data  = 32'h5A5A5A5A;
        csr_rep_valid = 1'b1;
        tick();
        csr_rep_valid = 1'b0;
        #1;
        check("edge_rsp_valid", rsp_valid, 1);
        check("edge_rsp_err", rsp_err, 0);
        check("edge_rsp_rdata", rsp_rdata, 32'h5A5A5A5A);
        check("edge_hung", hung, 0);
        take_rsp();

        // Timeout, then a fast error answer while hung
        issue(1'b1, 12'h123, 32'hFFFF0000);
        wait_rsp(lat);
        check("t4_timeout_latency", lat, 17);
        check("t4_err", rsp_err, 1);
        check("t4_rdata", rsp_rdata, 0);
        check("t4_hung", hung, 1);
        take_rsp();
        issue(1'b0, 12'h124, 32'h0);
        #1 check("t4_hung_no_req", csr_req_valid, 0);
        wait_rsp(lat);
        check("t4_hung_latency", lat, 1);
        check("t4_hung_err", rsp_err, 1);
        check("t4_hung_rdata", rsp_rdata, 0);
        take_rsp();

        // reset_req beats cmd_valid; late reply drained; hung cleared
        #1 check("t5_hung_before", hung, 1);
        reset_req = 1'b1;
        cmd_valid = 1'b1;
        cmd_addr  = 12'h0AA;
        #1 check("t5_cmd_blocked", cmd_ready, 0);
        tick();
        reset_req = 1'b0;
        cmd_valid = 1'b0;
        n_hi = 0;
        for (int i = 0; i < 64; i++) begin
            #1;
            if (!target_reset) break;
            n_hi++;
            if (i == 5) check("t5_drain_ready", csr_rep_ready, 1);
            csr_rep_valid = (i == 5);
            csr_rep_data  = 32'hBADBAD00;
            tick();
        end
        csr_rep_valid = 1'b0;
        check("t5_hold_len", n_hi, 16);
        #1 check("t5_hung_cleared", hung, 0);
        issue(1'b0, 12'h7B0, 32'h0);
        csr_rep_data  = 32'hCAFE0001;
        csr_rep_valid = 1'b1;
        wait_rsp(lat);
        csr_rep_valid = 1'b0;
        check("t5_read_err", rsp_err, 0);
        check("t5_read_rdata", rsp_rdata, 32'hCAFE0001);
        take_rsp();

        // Asynchronous reset in the middle of WAIT
        issue(1'b0, 12'h345, 32'h0);
        tick();
        #1 check("t6_in_wait", csr_rep_ready, 1);
        rst = 1'b0;
        model_reset();
        #1;
        check("t6_target_reset", target_reset, 1);
        check("t6_rep_ready", csr_rep_ready, 0);
        check("t6_rsp_valid", rsp_valid, 0);
        check("t6_req_valid", csr_req_valid, 0);
        check("t6_cmd_ready", cmd_ready, 0);
        check("t6_rsp_rdata", rsp_rdata, 0);
        check("t6_req_addr", csr_req_addr, 0);
        tick();
        tick();
        rst = 1'b1;
        hold_len(n_hi);
        check("t6_hold_len", n_hi, 16);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            cmd_valid     = ($urandom_range(0, 1) == 1);
            cmd_rw        = ($urandom_range(0, 1) == 1);
            cmd_addr      = ADDR_W'($urandom);
            cmd_wdata     = $urandom;
            reset_req     = ($urandom_range(0, 39) == 0);
            rsp_ready     = ($urandom_range(0, 2) != 0);
            csr_req_ready = ($urandom_range(0, 2) != 0);
            csr_rep_valid = ($urandom_range(0, 5) == 0);
            csr_rep_data  = $urandom;
            if ($urandom_range(0, 699) == 0) begin
                #1 rst = 1'b0;
                model_reset();
                tick();
                rst = 1'b1;
            end else begin
                tick();
            end
        end

        cmd_valid     = 1'b0;
        reset_req     = 1'b0;
        rsp_ready     = 1'b1;
        csr_req_ready = 1'b1;
        csr_rep_valid = 1'b1;
        repeat (40) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
